// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port to one-port memory arbiter.
package mem_arbiter_pkg;

  // Which requester currently owns the shared memory port.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_INSTR = 2'd1,
    GRANT_DATA  = 2'd2
  } MemArbState_t;

  // Bit positions inside the grant observability vector.
  localparam int GRANT_INSTR_IDX = 0;
  localparam int GRANT_DATA_IDX  = 1;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter.sv
// Serialises the fetch bus and the data bus onto one external memory port.
// The data side wins ties, the two sides alternate when both are pending,
// and lock keeps the data side granted across a read-modify-write sequence.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  // fetch bus
  input  logic [19:1] instr_m_addr,
  output logic [15:0] instr_m_data_in,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  // data bus
  input  logic [19:1] data_m_addr,
  output logic [15:0] data_m_data_in,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  input  logic        d_io,
  input  logic        lock,
  // shared port
  output logic [19:1] q_m_addr,
  input  logic [15:0] q_m_data_in,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic        q_io,
  // observability
  output logic [1:0]  grant
);

  MemArbState_t state_q, state_d;

  // State register; reset drops any grant immediately.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next owner: data priority from idle, hand-over on completion, lock pins the data side.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (data_m_access) begin
          state_d = GRANT_DATA;
        end else if (instr_m_access) begin
          state_d = GRANT_INSTR;
        end
      end
      GRANT_INSTR: begin
        if (q_m_ack) begin
          state_d = data_m_access ? GRANT_DATA : IDLE;
        end
      end
      GRANT_DATA: begin
        if (q_m_ack) begin
          if (lock) begin
            state_d = GRANT_DATA;
          end else if (instr_m_access) begin
            state_d = GRANT_INSTR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared-port mux; the fetch bus only ever reads whole words from memory space.
  always_comb begin
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_access   = 1'b0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    q_io         = 1'b0;
    unique case (state_q)
      GRANT_INSTR: begin
        q_m_addr    = instr_m_addr;
        q_m_access  = instr_m_access;
        q_m_bytesel = 2'b11;
      end
      GRANT_DATA: begin
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_access   = data_m_access;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
        q_io         = d_io;
      end
      default: ;
    endcase
  end

  // Grant vector and completion routing; acks reach only the granted side.
  always_comb begin
    grant                  = 2'b00;
    grant[GRANT_INSTR_IDX] = (state_q == GRANT_INSTR);
    grant[GRANT_DATA_IDX]  = (state_q == GRANT_DATA);
    instr_m_ack            = q_m_ack & grant[GRANT_INSTR_IDX];
    data_m_ack             = q_m_ack & grant[GRANT_DATA_IDX];
    instr_m_data_in        = q_m_data_in;
    data_m_data_in         = q_m_data_in;
  end

endmodule : mem_arbiter
